// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice datapath.
package synth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_t;

  localparam int ENV_WIDTH_DEF = 16;
  localparam logic [ENV_WIDTH_DEF-1:0] ENV_MAX_DEF = '1;

  // Full-scale envelope value for a given width; the 32-bit wrap still gives all ones at w=32.
  function automatic logic [31:0] env_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/env_scaler.sv
// Two-stage signed x unsigned gain pipeline: register the product, then the shifted result.
module env_scaler #(
  parameter int DATA_WIDTH = 32,
  parameter int ENV_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic        [ENV_WIDTH-1:0]  env_i,
  output logic signed [DATA_WIDTH-1:0] data_o
);

  localparam int PW = DATA_WIDTH + ENV_WIDTH + 1;

  logic signed [PW-1:0]         data_ext;
  logic signed [PW-1:0]         env_ext;
  logic signed [PW-1:0]         prod_d;
  logic signed [PW-1:0]         prod_q;
  logic signed [PW-1:0]         shift_d;
  logic signed [DATA_WIDTH-1:0] data_q;
  logic                         unused_shift_hi;

  // Gain is always below 1.0, so the product fits in PW bits and the truncated result cannot overflow.
  assign data_ext = {{(PW-DATA_WIDTH){data_i[DATA_WIDTH-1]}}, data_i};
  assign env_ext  = {{(PW-ENV_WIDTH){1'b0}}, env_i};
  assign prod_d   = data_ext * env_ext;
  assign shift_d  = prod_q >>> ENV_WIDTH;
  assign unused_shift_hi = ^shift_d[PW-1:DATA_WIDTH];
  assign data_o   = data_q;

  // Pipeline registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
      data_q <= '0;
    end else begin
      prod_q <= prod_d;
      data_q <= shift_d[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// Per-voice ADSR envelope generator and VCA, advanced once per sample strobe.
//
//   state   | meaning
//   IDLE    | voice silent, env held at 0
//   ATTACK  | env rising by attack_step per strobe toward full scale
//   DECAY   | env falling by decay_step per strobe toward sustain_level
//   SUSTAIN | env tracks sustain_level while the gate is held
//   RELEASE | env falling by release_step per strobe toward 0
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ENV_WIDTH  = ENV_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         step_in,
  input  logic                         gate_in,
  input  logic        [ENV_WIDTH-1:0]  attack_step,
  input  logic        [ENV_WIDTH-1:0]  decay_step,
  input  logic        [ENV_WIDTH-1:0]  sustain_level,
  input  logic        [ENV_WIDTH-1:0]  release_step,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic signed [DATA_WIDTH-1:0] data_out,
  output logic        [ENV_WIDTH-1:0]  env_out,
  output logic        [2:0]            state_out,
  output logic                         active_out
);

  localparam logic [ENV_WIDTH-1:0] ENV_MAX = ENV_WIDTH'(env_max(ENV_WIDTH));

  adsr_state_t          state_q, state_d;
  logic [ENV_WIDTH-1:0] env_q, env_d;
  logic                 active_q, active_d;

  logic [ENV_WIDTH:0]   attack_sum;
  logic [ENV_WIDTH:0]   decay_floor;

  // Widened so neither the attack overflow nor the decay floor can wrap.
  assign attack_sum  = {1'b0, env_q} + {1'b0, attack_step};
  assign decay_floor = {1'b0, sustain_level} + {1'b0, decay_step};

  // Next state and envelope; everything holds unless this is a strobe cycle.
  always_comb begin
    state_d = state_q;
    env_d   = env_q;
    if (step_in) begin
      unique case (state_q)
        ST_IDLE: begin
          if (gate_in) state_d = ST_ATTACK;
          else         env_d   = '0;
        end
        ST_ATTACK: begin
          if (!gate_in) begin
            state_d = ST_RELEASE;
          end else if (attack_sum >= {1'b0, ENV_MAX} || attack_step == '0) begin
            env_d   = ENV_MAX;
            state_d = ST_DECAY;
          end else begin
            env_d = attack_sum[ENV_WIDTH-1:0];
          end
        end
        ST_DECAY: begin
          // env <= sustain + step covers both the floor crossing and env < step.
          if (!gate_in) begin
            state_d = ST_RELEASE;
          end else if (decay_step == '0 || env_q <= sustain_level ||
                       {1'b0, env_q} <= decay_floor) begin
            env_d   = sustain_level;
            state_d = ST_SUSTAIN;
          end else begin
            env_d = env_q - decay_step;
          end
        end
        ST_SUSTAIN: begin
          if (!gate_in) state_d = ST_RELEASE;
          else          env_d   = sustain_level;
        end
        ST_RELEASE: begin
          // Retrigger keeps the current level so there is no click back to 0.
          if (gate_in) begin
            state_d = ST_ATTACK;
          end else if (env_q <= release_step || release_step == '0) begin
            env_d   = '0;
            state_d = ST_IDLE;
          end else begin
            env_d = env_q - release_step;
          end
        end
        default: begin
          state_d = ST_IDLE;
          env_d   = '0;
        end
      endcase
    end
    active_d = (state_d != ST_IDLE);
  end

  // State, envelope and activity registers; reset has priority over a coincident strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      env_q    <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      active_q <= active_d;
    end
  end

  assign env_out    = env_q;
  assign state_out  = state_q;
  assign active_out = active_q;

  env_scaler #(
    .DATA_WIDTH(DATA_WIDTH),
    .ENV_WIDTH (ENV_WIDTH)
  ) u_vca (
    .clk   (clk),
    .rst   (rst),
    .data_i(data_in),
    .env_i (env_q),
    .data_o(data_out)
  );

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with a queue-based scoreboard.
module tb_adsr_envelope;

  logic               clk = 1'b0;
  logic               rst;
  logic               step_in;
  logic               gate_in;
  logic        [15:0] attack_step;
  logic        [15:0] decay_step;
  logic        [15:0] sustain_level;
  logic        [15:0] release_step;
  logic signed [31:0] data_in;
  logic signed [31:0] data_out;
  logic        [15:0] env_out;
  logic        [2:0]  state_out;
  logic               active_out;

  typedef struct {
    string       tag;
    logic [15:0] env;
    logic [2:0]  st;
  } env_exp_t;

  typedef struct {
    string       tag;
    logic [31:0] dat;
  } vca_exp_t;

  env_exp_t env_q[$];
  vca_exp_t vca_q[$];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  adsr_envelope #(.DATA_WIDTH(32), .ENV_WIDTH(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .step_in      (step_in),
    .gate_in      (gate_in),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_level(sustain_level),
    .release_step (release_step),
    .data_in      (data_in),
    .data_out     (data_out),
    .env_out      (env_out),
    .state_out    (state_out),
    .active_out   (active_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic check_env_head();
    env_exp_t e;
    e = env_q.pop_front();
    chk({e.tag, ".env"}, 32'(env_out), 32'(e.env));
    chk({e.tag, ".state"}, 32'(state_out), 32'(e.st));
    chk({e.tag, ".active"}, 32'(active_out), 32'(e.st != 3'd0));
  endtask

  // Strobe once, then compare the registered result; three quiet cycles follow.
  task automatic strobe(input string tag, input logic [15:0] e_env, input logic [2:0] e_st);
    env_q.push_back('{tag, e_env, e_st});
    step_in = 1'b1;
    @(posedge clk); #1;
    step_in = 1'b0;
    check_env_head();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic vca(input string tag, input logic [31:0] din, input logic [31:0] e_dat);
    vca_exp_t v;
    data_in = din;
    vca_q.push_back('{tag, e_dat});
    repeat (2) @(posedge clk);
    #1;
    v = vca_q.pop_front();
    chk(v.tag, 32'(data_out), v.dat);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; step_in = 1'b0; gate_in = 1'b0;
    attack_step = 16'h4000; decay_step = 16'h3000;
    sustain_level = 16'h8000; release_step = 16'h3000;
    data_in = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    chk("reset.env", 32'(env_out), 32'h0);
    chk("reset.state", 32'(state_out), 32'h0);
    chk("reset.active", 32'(active_out), 32'h0);
    chk("reset.data", 32'(data_out), 32'h0);
    rst = 1'b0;
    gate_in = 1'b1;
    @(posedge clk); #1;

    strobe("atk0", 16'h0000, 3'd1);
    strobe("atk1", 16'h4000, 3'd1);
    strobe("atk2", 16'h8000, 3'd1);
    strobe("atk3", 16'hC000, 3'd1);
    strobe("atk_top", 16'hFFFF, 3'd2);
    vca("vca_full", 32'h4000_0000, 32'h3FFF_C000);
    chk("hold_no_step", 32'(env_out), 32'hFFFF);

    strobe("dec1", 16'hCFFF, 3'd2);
    strobe("dec2", 16'h9FFF, 3'd2);
    strobe("dec_sus", 16'h8000, 3'd3);
    vca("vca_half_neg", 32'hC000_0000, 32'hE000_0000);
    sustain_level = 16'h6000;
    strobe("sus_track", 16'h6000, 3'd3);
    sustain_level = 16'h8000;
    strobe("sus_back", 16'h8000, 3'd3);

    // Gate drop between strobes is ignored.
    gate_in = 1'b0;
    @(posedge clk); #1;
    gate_in = 1'b1;
    strobe("gate_glitch", 16'h8000, 3'd3);

    gate_in = 1'b0;
    strobe("rel_enter", 16'h8000, 3'd4);
    strobe("rel1", 16'h5000, 3'd4);
    gate_in = 1'b1;
    strobe("retrig", 16'h5000, 3'd1);
    attack_step = 16'h0000;
    strobe("atk_zero", 16'hFFFF, 3'd2);

    gate_in = 1'b0;
    release_step = 16'h8000;
    strobe("rel_enter2", 16'hFFFF, 3'd4);
    strobe("rel_big", 16'h7FFF, 3'd4);
    strobe("rel_idle", 16'h0000, 3'd0);
    vca("vca_zero", 32'h7FFF_FFFF, 32'h0000_0000);
    strobe("idle_hold", 16'h0000, 3'd0);

    gate_in = 1'b1;
    attack_step = 16'h4000;
    strobe("atk_b0", 16'h0000, 3'd1);
    strobe("atk_b1", 16'h4000, 3'd1);
    strobe("atk_b2", 16'h8000, 3'd1);
    vca("vca_mid", 32'h4000_0000, 32'h2000_0000);

    // Reset coincident with a strobe: reset wins, no release tail.
    rst = 1'b1; step_in = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; step_in = 1'b0;
    chk("rst_mid.env", 32'(env_out), 32'h0);
    chk("rst_mid.state", 32'(state_out), 32'h0);
    chk("rst_mid.active", 32'(active_out), 32'h0);
    chk("rst_mid.data", 32'(data_out), 32'h0);
    repeat (4) @(posedge clk); #1;
    chk("rst_no_step.state", 32'(state_out), 32'h0);
    strobe("post_rst_atk", 16'h0000, 3'd1);

    attack_step = 16'h0000;
    strobe("atk_zero2", 16'hFFFF, 3'd2);
    decay_step = 16'h0000;
    strobe("dec_zero", 16'h8000, 3'd3);

    chk("queues_empty", 32'(env_q.size() + vca_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/adsr_envelope.md
# adsr_envelope

Per-voice ADSR amplitude envelope and VCA stage that sits directly downstream of `oscillator`. It takes the oscillator's signed sample stream and a note gate, and advances an attack/decay/sustain/release envelope once per sample strobe. It scales each sample by the current envelope and passes the result to the voice mixer. It shares `step_in` with the oscillator, so envelope time constants are expressed in samples.

## Interface
- `DATA_WIDTH`, 32: sample width of `data_in` / `data_out`, signed two's complement.
- `ENV_WIDTH`, 16: envelope width, unsigned; full scale `ENV_MAX` = 2^ENV_WIDTH − 1.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `step_in`  in  1: one-cycle sample strobe, same signal that drives the oscillator.
- `gate_in`  in  1: note held (level).
- `attack_step`  in  ENV_WIDTH: envelope increment per step in ATTACK.
- `decay_step`  in  ENV_WIDTH: decrement per step in DECAY.
- `sustain_level`  in  ENV_WIDTH: SUSTAIN target.
- `release_step`  in  ENV_WIDTH: decrement per step in RELEASE.
- `data_in`  in  DATA_WIDTH signed: oscillator sample.
- `data_out`  out  DATA_WIDTH signed: enveloped sample.
- `env_out`  out  ENV_WIDTH: current envelope value.
- `state_out`  out  3: current `adsr_state_t` encoding.
- `active_out`  out  1: high whenever the state is not IDLE; used for voice allocation.

## Operation
- States, with encodings: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- State and `env` change only on cycles where `step_in`=1. On all other cycles they hold.
- Each step cycle, evaluate in this priority order:
  - Gate edge: `gate_in`=1 in IDLE or RELEASE → ATTACK. `gate_in`=0 in ATTACK, DECAY or SUSTAIN → RELEASE. On a transition step, `env` does not change. Retrigger from RELEASE starts from the current `env`, not from 0.
  - ATTACK: `env` += `attack_step`, computed at ENV_WIDTH+1 bits. If the sum ≥ `ENV_MAX` or `attack_step`=0, set `env`=`ENV_MAX` and go to DECAY in the same step.
  - DECAY: if `env` − `decay_step` ≤ `sustain_level`, or `decay_step`=0, or `env` is already ≤ `sustain_level`, set `env`=`sustain_level` and go to SUSTAIN. Otherwise subtract. The subtraction must not underflow.
  - SUSTAIN: `env` = `sustain_level` every step, so it tracks live changes.
  - RELEASE: if `env` ≤ `release_step` or `release_step`=0, set `env`=0 and go to IDLE. Otherwise subtract.
  - IDLE: `env` = 0.
- VCA: `data_out` = (`data_in` × {1'b0,`env`}) >>> ENV_WIDTH.
  - Signed multiply, DATA_WIDTH+ENV_WIDTH+1-bit product, arithmetic shift, then truncate to DATA_WIDTH.
  - The result never overflows, because `env` < 2^ENV_WIDTH.
  - The VCA runs every clock, independent of `step_in`.

## Timing
- Reset values: state IDLE, `env`=0, `env_out`=0, `state_out`=0, `active_out`=0, `data_out`=0, VCA pipeline registers cleared.
- Reset mid-note takes effect the next cycle, with no release tail.
- `env_out`, `state_out` and `active_out` are registered. They reflect the step update one cycle after the `step_in` cycle.
- VCA latency is 2 cycles: `data_in` at cycle n and the `env` register value at cycle n appear at `data_out` at cycle n+2.
  - Stage 1 registers the product.
  - Stage 2 registers the shifted and truncated result.
  - The oscillator output is registered and changes once per step, so `data_out` settles 2 cycles after `data_in` changes.
- The gate is sampled only on step cycles. A gate pulse that falls entirely between strobes is ignored.
- If `step_in` and `rst` are asserted in the same cycle, reset wins.

## Structure
- Shared package `synth_pkg`:
  - `typedef enum logic [2:0] adsr_state_t`
  - `ENV_WIDTH` default constant
  - `ENV_MAX` function/constant
- Sub-module `env_scaler`: the 2-stage signed×unsigned multiply-and-shift pipeline, parameterised by DATA_WIDTH and ENV_WIDTH. It is reused later by the mixer's gain stage.
- The top level contains the FSM, the envelope arithmetic and one `env_scaler` instance.

## Test plan
- Attack ramp: reset, then `attack_step`=0x4000, `gate_in`=1, strobe every 4 clocks → `env_out` reads 0x0000 (transition step), then 0x4000, 0x8000, 0xC000, then 0xFFFF with state DECAY.
- Decay/sustain: `decay_step`=0x3000, `sustain_level`=0x8000 → after reaching 0xFFFF, `env_out` reads 0xCFFF, 0x9FFF, then 0x8000 with SUSTAIN. Changing `sustain_level` to 0x6000 makes `env_out`=0x6000 on the next step.
- Release and idle: from SUSTAIN at 0x8000, `gate_in`=0 and `release_step`=0x3000 → RELEASE (env 0x8000), then 0x5000, 0x2000, then 0x0000 with IDLE and `active_out`=0.
- Retrigger and zero steps: from RELEASE at 0x5000, set `gate_in`=1 → ATTACK with env 0x5000. With `attack_step`=0, the next step gives env 0xFFFF and DECAY.
- VCA math: hold env at 0xFFFF with `data_in`=0x40000000 → `data_out`=0x3FFFC000 two cycles later. With env 0x8000 and `data_in`=0xC0000000 → 0xE0000000. With env 0 → 0.
- Reset mid-attack: assert `rst` for one cycle at env 0x8000 → next cycle all outputs 0 and state IDLE. No step occurs before the next gate edge.
